// File: rtl/bram_arb_pkg.sv
// Shared types and sizing helpers for the block RAM access arbiter.
package bram_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam int unsigned MIN_PTR_W = 1;

    // Round-robin pointer width; a single requester still needs one bit.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n <= 1) ? MIN_PTR_W : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts after the last granted requester.
module rr_arbiter
    import bram_arb_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int unsigned PW = ptr_width(N);

    logic [PW-1:0] r_last;
    logic [PW-1:0] w_grant_idx;
    logic          w_found;

    // Upper half (above last winner) first, then wrap to the lower half.
    always_comb begin
        grant       = '0;
        w_grant_idx = r_last;
        w_found     = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!w_found && req[i] && (PW'(i) > r_last)) begin
                grant[i]    = 1'b1;
                w_grant_idx = PW'(i);
                w_found     = 1'b1;
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (!w_found && req[i] && (PW'(i) <= r_last)) begin
                grant[i]    = 1'b1;
                w_grant_idx = PW'(i);
                w_found     = 1'b1;
            end
        end
    end

    // Reset points at the last requester so requester 0 wins first.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_last <= PW'(N - 1);
        end else if (advance && w_found) begin
            r_last <= w_grant_idx;
        end
    end

endmodule

// File: rtl/bram_access_arbiter.sv
// Shares one simple-dual-port read-first block RAM between NUM_REQ requesters,
// with round-robin read/write arbitration and a zero-fill clear sequencer.
module bram_access_arbiter
    import bram_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned ADDRESS_WIDTH = 11,
    parameter int unsigned NUM_REQ       = 2
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic [NUM_REQ-1:0]              rd_valid,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] rd_addr,
    output logic [NUM_REQ-1:0]              rd_ready,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_data,
    input  logic [NUM_REQ-1:0]              wr_valid,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] wr_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   wr_data,
    output logic [NUM_REQ-1:0]              wr_ready,
    input  logic                            clear_start,
    output logic                            clear_busy,
    output logic [ADDRESS_WIDTH-1:0]        mem_raddr,
    input  logic [DATA_WIDTH-1:0]           mem_dout,
    output logic                            mem_wen,
    output logic [ADDRESS_WIDTH-1:0]        mem_waddr,
    output logic [DATA_WIDTH-1:0]           mem_din
);

    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned AW = ADDRESS_WIDTH;
    localparam int unsigned N  = NUM_REQ;

    state_t        r_state;
    state_t        w_state_next;
    logic [AW-1:0] r_clr_cnt;
    logic [AW-1:0] w_clr_cnt_next;
    logic [N-1:0]  r_rsp_valid;

    logic          w_arb_en;
    logic          w_clearing;
    logic [N-1:0]  w_rd_req;
    logic [N-1:0]  w_wr_req;
    logic [N-1:0]  w_rd_grant;
    logic [N-1:0]  w_wr_grant;
    logic [AW-1:0] w_wr_addr;
    logic [DW-1:0] w_wr_data;

    // Grants only in IDLE and never while reset is asserted.
    assign w_arb_en   = reset_n && (r_state == IDLE);
    assign w_clearing = reset_n && (r_state == CLEAR);
    assign w_rd_req   = rd_valid & {N{w_arb_en}};
    assign w_wr_req   = wr_valid & {N{w_arb_en}};

    rr_arbiter #(.N(N)) u_rd_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (w_rd_req),
        .advance (w_arb_en),
        .grant   (w_rd_grant)
    );

    rr_arbiter #(.N(N)) u_wr_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (w_wr_req),
        .advance (w_arb_en),
        .grant   (w_wr_grant)
    );

    assign rd_ready = w_rd_grant;
    assign wr_ready = w_wr_grant;

    // One-hot grant muxes; all-zero when nothing is granted.
    always_comb begin
        mem_raddr = '0;
        w_wr_addr = '0;
        w_wr_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (w_rd_grant[i]) mem_raddr = rd_addr[i*AW +: AW];
            if (w_wr_grant[i]) begin
                w_wr_addr = wr_addr[i*AW +: AW];
                w_wr_data = wr_data[i*DW +: DW];
            end
        end
    end

    assign mem_wen   = w_clearing || (|w_wr_grant);
    assign mem_waddr = w_clearing ? r_clr_cnt : w_wr_addr;
    assign mem_din   = w_clearing ? '0 : w_wr_data;

    // Clear sequencer: one word per cycle, leaves after the last address.
    always_comb begin
        w_state_next   = r_state;
        w_clr_cnt_next = r_clr_cnt;
        case (r_state)
            IDLE: begin
                if (clear_start) begin
                    w_state_next   = CLEAR;
                    w_clr_cnt_next = '0;
                end
            end
            CLEAR: begin
                w_clr_cnt_next = r_clr_cnt + AW'(1);
                if (r_clr_cnt == '1) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_clr_cnt   <= '0;
            r_rsp_valid <= '0;
        end else begin
            r_state     <= w_state_next;
            r_clr_cnt   <= w_clr_cnt_next;
            r_rsp_valid <= w_rd_grant;
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = mem_dout;
    assign clear_busy = (r_state == CLEAR);

endmodule

// File: tb/tb_bram_access_arbiter.sv
// Self-checking bench for bram_access_arbiter: directed table, corner sequences,
// and randomized traffic against a behavioural arbitration/memory model.
module tb_bram_access_arbiter;

    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 16;
    localparam int unsigned N     = 2;
    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  rd_valid, rd_ready, rsp_valid, wr_valid, wr_ready;
    logic [7:0]  rd_addr, wr_addr;
    logic [31:0] wr_data;
    logic [15:0] rsp_data, mem_dout, mem_din;
    logic        clear_start, clear_busy, mem_wen;
    logic [3:0]  mem_raddr, mem_waddr;

    always #5 clk = ~clk;

    bram_access_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_REQ(N)) dut (
        .clock(clk), .reset_n(reset_n),
        .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .clear_start(clear_start), .clear_busy(clear_busy),
        .mem_raddr(mem_raddr), .mem_dout(mem_dout),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_din(mem_din)
    );

    // Read-first RAM macro with 1-cycle read latency.
    logic [15:0] ram [DEPTH];
    logic        ram_init;
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < int'(DEPTH); i++) ram[i] <= '0;
        end else if (mem_wen) begin
            ram[mem_waddr] <= mem_din;
        end
        mem_dout <= ram[mem_raddr];
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model state
    int          m_rd_last, m_wr_last, m_cnt, g_rd, g_wr;
    bit          m_clear;
    logic [1:0]  m_rsp_v;
    logic [15:0] m_rsp_d;
    logic [15:0] ref_mem [DEPTH];
    logic [1:0]  e_rd, e_wr;
    logic [3:0]  e_raddr, e_waddr;
    logic        e_wen;
    logic [15:0] e_din;

    function automatic int rr_pick(input logic [1:0] v, input int last);
        for (int k = 1; k <= int'(N); k++) begin
            int idx;
            idx = (last + k) % int'(N);
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    // Predict and compare all outputs for the current cycle.
    task automatic eval();
        #1;
        e_rd = '0; e_wr = '0; e_raddr = '0; e_waddr = '0; e_wen = 1'b0; e_din = '0;
        g_rd = -1; g_wr = -1;
        if (reset_n) begin
            if (m_clear) begin
                e_wen   = 1'b1;
                e_waddr = 4'(m_cnt);
            end else begin
                g_rd = rr_pick(rd_valid, m_rd_last);
                g_wr = rr_pick(wr_valid, m_wr_last);
                if (g_rd >= 0) begin
                    e_rd[g_rd] = 1'b1;
                    e_raddr    = rd_addr[g_rd*AW +: AW];
                end
                if (g_wr >= 0) begin
                    e_wr[g_wr] = 1'b1;
                    e_wen      = 1'b1;
                    e_waddr    = wr_addr[g_wr*AW +: AW];
                    e_din      = wr_data[g_wr*DW +: DW];
                end
            end
        end
        chk("rd_ready", rd_ready, e_rd);
        chk("wr_ready", wr_ready, e_wr);
        chk("mem_raddr", mem_raddr, e_raddr);
        chk("mem_wen", mem_wen, e_wen);
        chk("mem_waddr", mem_waddr, e_waddr);
        chk("mem_din", mem_din, e_din);
        chk("rsp_valid", rsp_valid, m_rsp_v);
        if (m_rsp_v != 2'b00) chk("rsp_data", rsp_data, m_rsp_d);
        chk("clear_busy", clear_busy, m_clear);
    endtask

    // Clock edge: advance the model with the predictions made in eval().
    task automatic adv();
        @(posedge clk);
        if (!reset_n) begin
            m_clear = 1'b0; m_cnt = 0; m_rsp_v = '0;
            m_rd_last = int'(N) - 1; m_wr_last = int'(N) - 1;
        end else begin
            m_rsp_v = e_rd;
            if (g_rd >= 0) m_rsp_d = ref_mem[e_raddr];
            if (e_wen) ref_mem[e_waddr] = e_din;
            if (g_rd >= 0) m_rd_last = g_rd;
            if (g_wr >= 0) m_wr_last = g_wr;
            if (m_clear) begin
                if (m_cnt == int'(DEPTH) - 1) m_clear = 1'b0;
                m_cnt = (m_cnt + 1) % int'(DEPTH);
            end else if (clear_start) begin
                m_clear = 1'b1; m_cnt = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic [1:0] rv, input logic [7:0] ra, input logic [1:0] wv,
                         input logic [7:0] wa, input logic [31:0] wd, input logic cs);
        rd_valid = rv; rd_addr = ra; wr_valid = wv; wr_addr = wa; wr_data = wd; clear_start = cs;
    endtask

    task automatic fill_all();
        for (int a = 0; a < int'(DEPTH); a++) begin
            logic [15:0] d;
            d = 16'($urandom) | 16'h0001;
            if (a % 2 == 1) drive(2'b00, 8'h00, 2'b10, {4'(a), 4'h0}, {d, 16'h0000}, 1'b0);
            else            drive(2'b00, 8'h00, 2'b01, {4'h0, 4'(a)}, {16'h0000, d}, 1'b0);
            eval(); adv();
        end
    endtask

    // Pulse clear_start, then count busy cycles; optional re-pulse at clear cycle k.
    task automatic run_clear(input int repulse_at, output int n_busy);
        int guard;
        bit done;
        n_busy = 0; guard = 0; done = 1'b0;
        drive(2'b00, 8'h00, 2'b00, 8'h00, 32'h0, 1'b1);
        eval(); adv();
        while (!done) begin
            drive(2'($urandom), 8'($urandom), (n_busy < 12) ? 2'($urandom) : 2'b00,
                  8'($urandom), $urandom, (repulse_at > 0) && (n_busy + 1 == repulse_at));
            eval();
            if (clear_busy === 1'b1) begin
                n_busy++;
                chk("clr_rd_block", rd_ready, 2'b00);
                chk("clr_wr_block", wr_ready, 2'b00);
            end else begin
                done = 1'b1;
            end
            adv();
            guard++;
            if (!done && guard >= 40) begin
                chk("clr_timeout", guard, 16);
                done = 1'b1;
            end
        end
    endtask

    typedef struct {
        logic [1:0]  rv;
        logic [7:0]  ra;
        logic [1:0]  wv;
        logic [7:0]  wa;
        logic [31:0] wd;
        logic [1:0]  x_rd;
        logic [1:0]  x_wr;
        logic [1:0]  x_rsp;
        logic [15:0] x_data;
    } vec_t;

    vec_t tbl [14];

    initial begin
        int nb;

        tbl[0]  = '{2'b00, 8'h00, 2'b01, 8'h03, 32'h0000BEEF, 2'b00, 2'b01, 2'b00, 16'h0000};
        tbl[1]  = '{2'b10, 8'h30, 2'b00, 8'h00, 32'h0,        2'b10, 2'b00, 2'b00, 16'h0000};
        tbl[2]  = '{2'b00, 8'h00, 2'b00, 8'h00, 32'h0,        2'b00, 2'b00, 2'b10, 16'hBEEF};
        tbl[3]  = '{2'b11, 8'h03, 2'b00, 8'h00, 32'h0,        2'b01, 2'b00, 2'b00, 16'h0000};
        tbl[4]  = '{2'b11, 8'h03, 2'b00, 8'h00, 32'h0,        2'b10, 2'b00, 2'b01, 16'hBEEF};
        tbl[5]  = '{2'b11, 8'h03, 2'b00, 8'h00, 32'h0,        2'b01, 2'b00, 2'b10, 16'h0000};
        tbl[6]  = '{2'b11, 8'h03, 2'b00, 8'h00, 32'h0,        2'b10, 2'b00, 2'b01, 16'hBEEF};
        tbl[7]  = '{2'b11, 8'h03, 2'b00, 8'h00, 32'h0,        2'b01, 2'b00, 2'b10, 16'h0000};
        tbl[8]  = '{2'b11, 8'h03, 2'b00, 8'h00, 32'h0,        2'b10, 2'b00, 2'b01, 16'hBEEF};
        tbl[9]  = '{2'b00, 8'h00, 2'b00, 8'h00, 32'h0,        2'b00, 2'b00, 2'b10, 16'h0000};
        tbl[10] = '{2'b01, 8'h05, 2'b01, 8'h05, 32'h00001234, 2'b01, 2'b01, 2'b00, 16'h0000};
        tbl[11] = '{2'b00, 8'h00, 2'b00, 8'h00, 32'h0,        2'b00, 2'b00, 2'b01, 16'h0000};
        tbl[12] = '{2'b10, 8'h50, 2'b00, 8'h00, 32'h0,        2'b10, 2'b00, 2'b00, 16'h0000};
        tbl[13] = '{2'b00, 8'h00, 2'b00, 8'h00, 32'h0,        2'b00, 2'b00, 2'b10, 16'h1234};

        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
        m_clear = 1'b0; m_cnt = 0; m_rsp_v = '0; m_rsp_d = '0;
        m_rd_last = int'(N) - 1; m_wr_last = int'(N) - 1;
        ram_init = 1'b1;
        reset_n  = 1'b0;
        drive(2'b00, 8'h00, 2'b00, 8'h00, 32'h0, 1'b0);
        repeat (2) @(negedge clk);
        ram_init = 1'b0;

        // Reset holds every grant and strobe low even with all requests active.
        drive(2'b11, 8'h35, 2'b11, 8'h21, 32'h55AA_A55A, 1'b1);
        eval();
        chk("rst_rd_ready", rd_ready, 2'b00);
        chk("rst_mem_wen", mem_wen, 1'b0);
        adv();
        reset_n = 1'b1;

        // Directed write/read, alternation and same-address read-first.
        for (int t = 0; t < 14; t++) begin
            drive(tbl[t].rv, tbl[t].ra, tbl[t].wv, tbl[t].wa, tbl[t].wd, 1'b0);
            eval();
            chk("t_rd_ready", rd_ready, tbl[t].x_rd);
            chk("t_wr_ready", wr_ready, tbl[t].x_wr);
            chk("t_rsp_valid", rsp_valid, tbl[t].x_rsp);
            if (tbl[t].x_rsp != 2'b00) chk("t_rsp_data", rsp_data, tbl[t].x_data);
            adv();
        end

        // Full clear after filling memory, then every word reads zero.
        fill_all();
        run_clear(0, nb);
        chk("clr_len", nb, 16);
        for (int a = 0; a <= int'(DEPTH); a++) begin
            if (a < int'(DEPTH)) drive(2'b01, {4'h0, 4'(a)}, 2'b00, 8'h00, 32'h0, 1'b0);
            else                 drive(2'b00, 8'h00, 2'b00, 8'h00, 32'h0, 1'b0);
            eval();
            if (a > 0) begin
                chk("clr_zero_v", rsp_valid, 2'b01);
                chk("clr_zero", rsp_data, 16'h0000);
            end
            adv();
        end

        // Second clear_start during a clear is ignored.
        fill_all();
        run_clear(5, nb);
        chk("clr_len_repulse", nb, 16);

        // Reset on the 7th clear cycle, then requester 0 wins contention.
        drive(2'b01, 8'h00, 2'b01, 8'h00, 32'h1, 1'b0);
        eval(); adv();
        drive(2'b00, 8'h00, 2'b00, 8'h00, 32'h0, 1'b1);
        eval(); adv();
        for (int c = 1; c <= 6; c++) begin
            drive(2'b00, 8'h00, 2'b00, 8'h00, 32'h0, 1'b0);
            eval(); adv();
        end
        reset_n = 1'b0;
        eval(); adv();
        reset_n = 1'b1;
        drive(2'b11, 8'h21, 2'b11, 8'h43, 32'h1111_2222, 1'b0);
        eval();
        chk("rst_mid_busy", clear_busy, 1'b0);
        chk("rst_mid_rsp", rsp_valid, 2'b00);
        chk("rst_rd_win", rd_ready, 2'b01);
        chk("rst_wr_win", wr_ready, 2'b01);
        adv();

        // Randomized traffic with occasional clears and resets.
        for (int n = 0; n < 600; n++) begin
            reset_n = ($urandom_range(0, 199) != 0);
            drive(2'($urandom), 8'($urandom), 2'($urandom), 8'($urandom), $urandom,
                  $urandom_range(0, 59) == 0);
            eval(); adv();
        end
        reset_n = 1'b1;
        drive(2'b00, 8'h00, 2'b00, 8'h00, 32'h0, 1'b0);
        eval(); adv();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
